// File: rtl/cmp_sequencer_if.sv
// Request/response bundle between the CPU compare logic and the byte-serial compare sequencer.
// The CPU side drives the operands and start, and the sequencer returns busy, done and result.
interface cmp_sequencer_if #(
  parameter int NBYTES = 4
);
  logic                  start;
  logic                  signed_en;
  logic [8*NBYTES-1:0]   op_a;
  logic [8*NBYTES-1:0]   op_b;
  logic                  busy;
  logic                  done;
  logic [7:0]            result;

  modport master (
    output start, signed_en, op_a, op_b,
    input  busy, done, result
  );

  modport slave (
    input  start, signed_en, op_a, op_b,
    output busy, done, result
  );
endinterface

// File: rtl/cmp_sequencer.sv
// Byte-serial multi-byte compare on a shared 8-bit comparator, MSB first, exiting early on the first unequal byte.
// Takes 1..NBYTES compare cycles plus one done cycle; start is accepted only when idle, and is dropped while busy.
module cmp_sequencer #(
  parameter int NBYTES = 4
) (
  input  logic             clk,
  input  logic             reset,
  cmp_sequencer_if.slave   bus,
  output logic [7:0]       cmp_a,
  output logic [7:0]       cmp_b,
  input  logic [7:0]       cmp_result
);
  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;

  state_t                 state_q, state_d;
  logic [IDXW-1:0]        idx_q, idx_d;
  logic [NBYTES-1:0][7:0] opa_q, opb_q;
  logic                   sgn_q;
  logic [7:0]             result_q, result_d;
  logic [7:0]             res_norm;
  logic                   load;
  logic                   bias;

  // Any nonzero comparator code other than 01/FF is folded by its sign bit.
  always_comb begin
    res_norm = 8'h00;
    if (cmp_result != 8'h00)
      res_norm = cmp_result[7] ? 8'hFF : 8'h01;
  end

  // Flipping the sign bit of the top byte turns a signed compare into an unsigned one.
  assign bias = sgn_q && (idx_q == IDXW'(NBYTES - 1));

  always_comb begin
    cmp_a = 8'h00;
    cmp_b = 8'h00;
    if (state_q == COMPARE) begin
      cmp_a = opa_q[idx_q] ^ {bias, 7'b0};
      cmp_b = opb_q[idx_q] ^ {bias, 7'b0};
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    result_d = result_q;
    load     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          idx_d   = IDXW'(NBYTES - 1);
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        if (res_norm != 8'h00) begin
          result_d = res_norm;
          state_d  = DONE;
        end else if (idx_q == '0) begin
          result_d = 8'h00;
          state_d  = DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      sgn_q    <= 1'b0;
      result_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      if (load) begin
        opa_q <= bus.op_a;
        opb_q <= bus.op_b;
        sgn_q <= bus.signed_en;
      end
    end
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;
endmodule

// File: tb/tb_cmp_sequencer.sv
// Directed bench for cmp_sequencer with a behavioural 8-bit comparator and an override for odd result codes.
module tb_cmp_sequencer;
  localparam int NBYTES = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] cmp_a, cmp_b, cmp_result, model_res, ovr_val;
  logic       ovr_en;

  always #5 clk = ~clk;

  cmp_sequencer_if #(.NBYTES(NBYTES)) bus ();

  assign model_res  = (cmp_a > cmp_b) ? 8'h01 : ((cmp_a < cmp_b) ? 8'hFF : 8'h00);
  assign cmp_result = ovr_en ? ovr_val : model_res;

  cmp_sequencer #(.NBYTES(NBYTES)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.slave),
    .cmp_a      (cmp_a),
    .cmp_b      (cmp_b),
    .cmp_result (cmp_result)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  int         ncmp;
  logic [7:0] seen_a [8];
  logic [7:0] seen_b [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launches one op, scrambles the inputs after accept, and checks length and result.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sgn, input logic [7:0] exp_res, input int exp_ncmp);
    bus.op_a = a; bus.op_b = b; bus.signed_en = sgn; bus.start = 1'b1;
    tick();
    bus.start = 1'b0; bus.op_a = ~a; bus.op_b = ~b; bus.signed_en = ~sgn;
    ncmp = 0;
    for (int i = 0; i < 20 && !bus.done; i++) begin
      if (ncmp < 8) begin
        seen_a[ncmp] = cmp_a;
        seen_b[ncmp] = cmp_b;
      end
      ncmp++;
      tick();
    end
    check({tag, "_done"},   32'(bus.done),   32'd1);
    check({tag, "_ncmp"},   32'(ncmp),       32'(exp_ncmp));
    check({tag, "_result"}, 32'(bus.result), 32'(exp_res));
    tick();
    check({tag, "_idle"},   {bus.busy, bus.done, cmp_a, cmp_b}, 32'd0);
    check({tag, "_held"},   32'(bus.result), 32'(exp_res));
  endtask

  initial begin
    int ndone, d0, d1, badres;
    logic [7:0] res_at_done;

    reset = 1'b1; ovr_en = 1'b0; ovr_val = 8'h00;
    bus.start = 1'b0; bus.signed_en = 1'b0; bus.op_a = '0; bus.op_b = '0;
    tick(); tick();
    reset = 1'b0;
    check("reset_state", {bus.busy, bus.done, bus.result, cmp_a, cmp_b}, 32'd0);

    run_op("eq_unsigned", 32'h12345678, 32'h12345678, 1'b0, 8'h00, 4);
    check("eq_bytes_a", {seen_a[0], seen_a[1], seen_a[2], seen_a[3]}, 32'h12345678);

    run_op("top_unsigned", 32'h80000000, 32'h7FFFFFFF, 1'b0, 8'h01, 1);
    run_op("top_signed",   32'h80000000, 32'h7FFFFFFF, 1'b1, 8'hFF, 1);
    check("signed_bias", {16'h0, seen_a[0], seen_b[0]}, 32'h000000FF);

    run_op("low_byte_lt", 32'h12345677, 32'h12345678, 1'b0, 8'hFF, 4);
    run_op("signed_neg_eq_hi", 32'hFF000001, 32'hFF000000, 1'b1, 8'h01, 4);

    ovr_en = 1'b1; ovr_val = 8'h42;
    run_op("norm_pos", 32'h0, 32'h0, 1'b0, 8'h01, 1);
    ovr_val = 8'hC3;
    run_op("norm_neg", 32'h0, 32'h0, 1'b0, 8'hFF, 1);
    ovr_en = 1'b0;

    // Second start during the op must be dropped, not queued.
    bus.op_a = 32'h12345679; bus.op_b = 32'h12345678; bus.signed_en = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    bus.op_a = 32'h00000001; bus.op_b = 32'h00000002; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    ndone = 0; res_at_done = 8'h00;
    for (int c = 0; c < 12; c++) begin
      if (bus.done) begin
        ndone++;
        res_at_done = bus.result;
      end
      tick();
    end
    check("busy_start_ndone",  32'(ndone),       32'd1);
    check("busy_start_result", 32'(res_at_done), 32'h01);
    check("busy_start_idle",   32'(bus.busy),    32'd0);

    bus.op_a = 32'hAABBCCDD; bus.op_b = 32'hAABBCCDD; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_state", {bus.busy, bus.done, bus.result, cmp_a, cmp_b}, 32'd0);
    ndone = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus.done || bus.busy) ndone++;
      tick();
    end
    check("abort_no_done", 32'(ndone), 32'd0);
    run_op("after_abort", 32'h00000100, 32'h00000200, 1'b0, 8'hFF, 3);

    // Continuous start: one op every NBYTES+2 cycles, each ending equal.
    bus.op_a = 32'hA5A5A5A5; bus.op_b = 32'hA5A5A5A5; bus.signed_en = 1'b0; bus.start = 1'b1;
    tick();
    ndone = 0; d0 = -1; d1 = -1; badres = 0;
    for (int c = 0; c < 18; c++) begin
      if (bus.done) begin
        if (ndone == 0) d0 = c;
        if (ndone == 1) d1 = c;
        ndone++;
        if (bus.result !== 8'h00) badres++;
      end
      tick();
    end
    bus.start = 1'b0;
    check("hold_ndone",  32'(ndone),   32'd3);
    check("hold_first",  32'(d0),      32'd4);
    check("hold_period", 32'(d1 - d0), 32'(NBYTES + 2));
    check("hold_result", 32'(badres),  32'd0);
    for (int c = 0; c < 8 && bus.busy; c++) tick();
    check("hold_drain", 32'(bus.busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
